ipm2t_hssthp_hpll_rst_arb: RTL and testbench

IPM2T_HSSTHP_HPLL_RST_ARB -- requirements
Module: ipm2t_hssthp_hpll_rst_arb

---
 rtl/ipm2t_hssthp_hpll_rst_arb.sv | 182 ++++++++++++++++++
 tb/tb_ipm2t_hssthp_hpll_rst_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipm2t_hssthp_hpll_rst_arb.sv
// Round-robin arbiter that lets NUM_REQ lanes share one HPLL reset sequencer.
// Define IPM2T_HSST_HPLL_ARB_TIMEOUT_EN to add the done-handshake timeout/retry.
module ipm2t_hssthp_hpll_rst_arb #(
    parameter int NUM_REQ             = 4,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int DONE_TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_hpll_done,
    output logic               o_hpll_rst,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [NUM_REQ-1:0] o_ack,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT_LOW,
        S_WAIT_DONE,
        S_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               hrst_q, hrst_d;
    logic               busy_q, busy_d;
    logic               rr_hit;
    logic [PTR_W-1:0]   rr_idx;

    // Search starts one past the last winner so every requester waits at most NUM_REQ-1 sequences.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!rr_hit && i_req[cand]) begin
                rr_hit = 1'b1;
                rr_idx = PTR_W'(cand);
            end
        end
    end

`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
    logic        tmo_expire;

    assign tmo_expire = (tmo_q == 16'(DONE_TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (DONE_TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        hrst_d  = hrst_q;
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rr_hit) begin
                    state_d = S_RST;
                    ptr_d   = rr_idx;
                    gnt_d   = NUM_REQ'(1) << rr_idx;
                    hrst_d  = 1'b1;
                    cnt_d   = 16'(RST_PULSE_CYCLES - 1);
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_LOW;
                    hrst_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT_LOW: begin
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
                if (tmo_expire) begin
                    state_d   = S_RST;
                    hrst_d    = 1'b1;
                    cnt_d     = 16'(RST_PULSE_CYCLES - 1);
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (!i_hpll_done) state_d = S_WAIT_DONE;
                end
`else
                if (!i_hpll_done) state_d = S_WAIT_DONE;
`endif
            end
            S_WAIT_DONE: begin
                // A done seen on the expiry cycle still wins, so ack and timeout stay exclusive.
                if (i_hpll_done) begin
                    state_d = S_ACK;
                    ack_d   = gnt_q;
                end
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
                else if (tmo_expire) begin
                    state_d   = S_RST;
                    hrst_d    = 1'b1;
                    cnt_d     = 16'(RST_PULSE_CYCLES - 1);
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_ACK: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                hrst_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            hrst_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            hrst_q  <= hrst_d;
            busy_q  <= busy_d;
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_hpll_rst = hrst_q;
    assign o_gnt      = gnt_q;
    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
    assign o_timeout  = timeout_q;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ipm2t_hssthp_hpll_rst_arb.sv
// Directed bench for ipm2t_hssthp_hpll_rst_arb: vector table plus multi-cycle sequences.
module tb_ipm2t_hssthp_hpll_rst_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_req;
    logic       i_hpll_done;
    logic       o_hpll_rst;
    logic [3:0] o_gnt;
    logic [3:0] o_ack;
    logic       o_busy;
    logic       o_timeout;

    int n_chk  = 0;
    int n_fail = 0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_gnt  = '0;

    ipm2t_hssthp_hpll_rst_arb #(
        .NUM_REQ(4),
        .RST_PULSE_CYCLES(16),
        .DONE_TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_hpll_done(i_hpll_done),
        .o_hpll_rst(o_hpll_rst),
        .o_gnt(o_gnt),
        .o_ack(o_ack),
        .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       hrst;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock, sampled on the falling edge, with invariant checks every cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("ack_tmo_excl", 32'((o_ack != 4'h0) && o_timeout), 32'd0);
        if (prev_busy && o_busy) chk("gnt_stable", 32'(o_gnt), 32'(prev_gnt));
        prev_busy = o_busy;
        prev_gnt  = o_gnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 4'h0;
        i_hpll_done = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_seq(input int exp_idx, input int exp_wait);
        int w;
        int hi;
        w = 0;
        hi = 0;
        while (o_gnt == 4'h0 && w < 40) begin
            step();
            w++;
        end
        if (exp_wait >= 0) chk("idle_gap", 32'(w), 32'(exp_wait));
        chk("gnt", 32'(o_gnt), 32'(4'b1 << exp_idx));
        chk("rst_on", 32'(o_hpll_rst), 32'd1);
        while (o_hpll_rst && hi < 100) begin
            hi++;
            step();
        end
        chk("rst_width", 32'(hi), 32'd16);
        i_hpll_done = 1'b0;
        step();
        step();
        i_hpll_done = 1'b1;
        w = 0;
        while (o_ack == 4'h0 && w < 10) begin
            step();
            w++;
        end
        chk("ack_lat", 32'(w), 32'd1);
        chk("ack", 32'(o_ack), 32'(4'b1 << exp_idx));
        chk("gnt_held", 32'(o_gnt), 32'(4'b1 << exp_idx));
        step();
        chk("gnt_clr", 32'(o_gnt), 32'd0);
        chk("ack_one", 32'(o_ack), 32'd0);
        chk("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int seen;
        int w;

        //            n  rst req   done gnt   hrst ack   busy
        tbl[0] = '{2, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{1, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 4'h0, 1'b1};
        tbl[2] = '{15, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 4'h0, 1'b1};
        tbl[3] = '{1, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1};
        tbl[4] = '{5, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1};
        tbl[5] = '{1, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 1'b1};
        tbl[6] = '{10, 1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 1'b1};
        tbl[7] = '{1, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 4'h2, 1'b1};
        tbl[8] = '{1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[9] = '{3, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0};

        rst = 1'b1;
        i_req = 4'h0;
        i_hpll_done = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            i_req = tbl[i].req;
            i_hpll_done = tbl[i].done;
            repeat (tbl[i].n) step();
            chk($sformatf("v%0d_gnt", i), 32'(o_gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_hrst", i), 32'(o_hpll_rst), 32'(tbl[i].hrst));
            chk($sformatf("v%0d_ack", i), 32'(o_ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_tmo", i), 32'(o_timeout), 32'd0);
        end

        // Contention: all four held, expect 0,1,2,3,0 with one IDLE cycle between.
        do_reset();
        i_req = 4'hF;
        run_seq(0, -1);
        run_seq(1, 1);
        run_seq(2, 1);
        run_seq(3, 1);
        run_seq(0, 1);

        // Requester 2 pulses its request for a single cycle.
        do_reset();
        i_req = 4'h4;
        step();
        i_req = 4'h0;
        run_seq(2, 0);
        seen = 0;
        repeat (5) begin
            step();
            if (o_ack != 4'h0 || o_gnt != 4'h0) seen++;
        end
        chk("drop_no_more_ack", 32'(seen), 32'd0);

        // Reset on the 5th cycle of the reset pulse.
        do_reset();
        i_req = 4'h4;
        step();
        chk("mid_gnt", 32'(o_gnt), 32'h4);
        repeat (4) step();
        rst = 1'b1;
        i_req = 4'h0;
        step();
        rst = 1'b0;
        chk("mid_hrst", 32'(o_hpll_rst), 32'd0);
        chk("mid_gnt0", 32'(o_gnt), 32'd0);
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_ack", 32'(o_ack), 32'd0);
        seen = 0;
        repeat (3) begin
            step();
            if (o_ack != 4'h0 || o_busy) seen++;
        end
        chk("mid_quiet", 32'(seen), 32'd0);
        i_req = 4'hF;
        step();
        chk("mid_restart_gnt", 32'(o_gnt), 32'h1);
        i_req = 4'h0;
        run_seq(0, 0);

        // Done stuck low.
        do_reset();
        i_hpll_done = 1'b0;
        i_req = 4'h1;
        step();
        i_req = 4'h0;
        w = 0;
        while (o_hpll_rst && w < 100) begin
            step();
            w++;
        end
        chk("stuck_rst_width", 32'(w), 32'd16);
`ifdef IPM2T_HSST_HPLL_ARB_TIMEOUT_EN
        w = 0;
        while (!o_timeout && w < 300) begin
            step();
            w++;
        end
        chk("tmo_delay", 32'(w), 32'd100);
        chk("tmo_retry_rst", 32'(o_hpll_rst), 32'd1);
        chk("tmo_gnt", 32'(o_gnt), 32'h1);
        chk("tmo_no_ack", 32'(o_ack), 32'd0);
        step();
        chk("tmo_pulse_one", 32'(o_timeout), 32'd0);
        chk("tmo_rst_held", 32'(o_hpll_rst), 32'd1);
`else
        seen = 0;
        repeat (200) begin
            step();
            if (o_timeout || o_ack != 4'h0) seen++;
        end
        chk("no_tmo", 32'(seen), 32'd0);
        chk("no_tmo_busy", 32'(o_busy), 32'd1);
        chk("no_tmo_gnt", 32'(o_gnt), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
